// File: rtl/reaction_timer_multi.sv
// rtl/reaction_timer_multi.sv - multi-player reaction timer: countdown, random wait, per-player timing, winner and best time
module reaction_timer_multi #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int NUM_PLAYERS  = 2,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 12,
  parameter int TIMEOUT_MS   = 9999,
  parameter int HOLD_S       = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_PLAYERS-1:0]    stop,
  input  logic                      random_en,
  output logic                      stimulus,
  output logic [2:0]                state_o,
  output logic [1:0]                countdown,
  output logic [NUM_PLAYERS*14-1:0] result_ms,
  output logic [NUM_PLAYERS-1:0]    fail,
  output logic                      result_valid,
  output logic [2:0]                winner,
  output logic [13:0]               best_ms,
  output logic                      new_best
);

  localparam int          TICK_DIV   = CLK_HZ / 1000;
  localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [13:0] TIMEOUT14  = 14'(TIMEOUT_MS);
  localparam logic [31:0] TIMEOUT_W  = 32'(TIMEOUT_MS);
  localparam logic [31:0] HOLD_TICKS = 32'(HOLD_S * 1000);
  localparam logic [31:0] MIN_W      = 32'(MIN_DELAY_MS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_WAIT      = 3'd2,
    S_ARMED     = 3'd3,
    S_RESULT    = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic [31:0]                ms_q, ms_d;
  logic [31:0]                delay_q, delay_d;
  logic [1:0]                 cd_q, cd_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic [NUM_PLAYERS*14-1:0]  res_q, res_d;
  logic [NUM_PLAYERS-1:0]     fail_q, fail_d;
  logic [NUM_PLAYERS-1:0]     done_q, done_d;
  logic [2:0]                 winner_q, winner_d;
  logic [13:0]                best_q, best_d;
  logic                       new_best_q, new_best_d;
  logic                       start_q;
  logic [NUM_PLAYERS-1:0]     stop_q;

  logic                       ms_tick, start_rise;
  logic [NUM_PLAYERS-1:0]     stop_rise;
  logic                       win_found;
  logic [2:0]                 win_idx;
  logic [13:0]                win_ms;

  assign ms_tick    = (presc_q == PW'(TICK_DIV - 1));
  assign start_rise = start & ~start_q;
  assign stop_rise  = stop & ~stop_q;

  always_comb begin
    state_d    = state_q;
    presc_d    = ms_tick ? '0 : presc_q + 1'b1;
    ms_d       = ms_q;
    delay_d    = delay_q;
    cd_d       = cd_q;
    res_d      = res_q;
    fail_d     = fail_q;
    done_d     = done_q;
    winner_d   = winner_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    win_found  = 1'b0;
    win_idx    = 3'd7;
    win_ms     = '1;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d  = S_COUNTDOWN;
          presc_d  = '0;
          ms_d     = '0;
          cd_d     = 2'd3;
          res_d    = '0;
          fail_d   = '0;
          done_d   = '0;
          winner_d = '0;
        end
      end
      S_COUNTDOWN, S_WAIT: begin
        // done marks a player whose round is over, whether by false start or by a latched time
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (stop_rise[i] && !done_q[i]) begin
            fail_d[i]        = 1'b1;
            done_d[i]        = 1'b1;
            res_d[i*14 +: 14] = TIMEOUT14;
          end
        end
        if (&done_d) begin
          state_d = S_RESULT;
        end else if (ms_tick) begin
          if (state_q == S_COUNTDOWN) begin
            if (ms_q == 32'd999) begin
              ms_d = '0;
              if (cd_q == 2'd1) begin
                state_d = S_WAIT;
                cd_d    = 2'd0;
                delay_d = MIN_W + (random_en ? 32'(lfsr_q[RAND_BITS-1:0]) : 32'd0);
              end else begin
                cd_d = cd_q - 2'd1;
              end
            end else begin
              ms_d = ms_q + 32'd1;
            end
          end else if (ms_q + 32'd1 >= delay_q) begin
            state_d = S_ARMED;
            presc_d = '0;
            ms_d    = '0;
          end else begin
            ms_d = ms_q + 32'd1;
          end
        end
      end
      S_ARMED: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (stop_rise[i] && !done_q[i]) begin
            res_d[i*14 +: 14] = ms_q[13:0];
            done_d[i]         = 1'b1;
          end
        end
        if (ms_tick && ms_q < TIMEOUT_W) ms_d = ms_q + 32'd1;
        if (&done_d) begin
          state_d = S_RESULT;
        end else if (ms_q >= TIMEOUT_W) begin
          state_d = S_RESULT;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!done_d[i]) begin
              fail_d[i]         = 1'b1;
              done_d[i]         = 1'b1;
              res_d[i*14 +: 14] = TIMEOUT14;
            end
          end
        end
      end
      S_RESULT: begin
        if (start_rise) begin
          state_d = S_IDLE;
        end else if (ms_tick) begin
          if (ms_q + 32'd1 >= HOLD_TICKS) state_d = S_IDLE;
          else                            ms_d    = ms_q + 32'd1;
        end
        if (state_d == S_IDLE) new_best_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // winner and best time are decided once, from the final per-player results
    if (state_d == S_RESULT && state_q != S_RESULT) begin
      ms_d = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (!fail_d[i] && (!win_found || res_d[i*14 +: 14] < win_ms)) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
          win_ms    = res_d[i*14 +: 14];
        end
      end
      winner_d = win_idx;
      if (win_found && win_ms < best_q) begin
        best_d     = win_ms;
        new_best_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      ms_q       <= '0;
      delay_q    <= '0;
      cd_q       <= '0;
      lfsr_q     <= 16'hACE1;
      res_q      <= '0;
      fail_q     <= '0;
      done_q     <= '0;
      winner_q   <= '0;
      best_q     <= 14'h3FFF;
      new_best_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      delay_q    <= delay_d;
      cd_q       <= cd_d;
      lfsr_q     <= lfsr_d;
      res_q      <= res_d;
      fail_q     <= fail_d;
      done_q     <= done_d;
      winner_q   <= winner_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
      start_q    <= start;
      stop_q     <= stop;
    end
  end

  assign stimulus     = (state_q == S_ARMED);
  assign state_o      = 3'(state_q);
  assign countdown    = (state_q == S_COUNTDOWN) ? cd_q : 2'd0;
  assign result_ms    = res_q;
  assign fail         = fail_q;
  assign result_valid = (state_q == S_RESULT);
  assign winner       = winner_q;
  assign best_ms      = best_q;
  assign new_best     = new_best_q;

endmodule
